// File: rtl/eth_mac_conf_pkg.sv
// Shared types, register/vector bit positions and packing helpers for the
// runtime MAC configuration block.
package eth_mac_conf_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_QUIESCE, ST_APPLY} state_t;

  localparam logic [1:0] REG_MAC_LO = 2'd0;
  localparam logic [1:0] REG_MAC_HI = 2'd1;
  localparam logic [1:0] REG_TX     = 2'd2;
  localparam logic [1:0] REG_RX     = 2'd3;

  localparam int RB_EN     = 16;
  localparam int RB_VLAN   = 17;
  localparam int RB_JUMBO  = 18;
  localparam int RB_TX_DIC = 19;
  localparam int RB_RX_FLC = 19;
  localparam int RB_RX_LTC = 20;

  localparam int VB_MAC_LSB = 32;
  localparam int VB_LEN_LSB = 16;
  localparam int VB_DIC     = 10;
  localparam int VB_FLC     = 9;
  localparam int VB_LTC     = 8;
  localparam int VB_JUMBO   = 4;
  localparam int VB_VLAN    = 2;
  localparam int VB_EN      = 1;

  typedef struct packed {
    logic [47:0] mac;
    logic [14:0] tx_len;
    logic        tx_en;
    logic        tx_vlan;
    logic        tx_jumbo;
    logic        tx_dic;
    logic [14:0] rx_len;
    logic        rx_en;
    logic        rx_vlan;
    logic        rx_jumbo;
    logic        rx_flc_dis;
    logic        rx_ltc_dis;
  } port_cfg_t;

  function automatic logic [79:0] pack_vec(input logic [47:0] mac, input logic [14:0] len,
                                           input logic en, input logic vlan, input logic jumbo,
                                           input logic dic, input logic flc, input logic ltc);
    logic [79:0] v;
    v = '0;
    v[VB_MAC_LSB +: 48] = mac;
    v[VB_LEN_LSB +: 15] = len;
    v[VB_DIC]   = dic;
    v[VB_FLC]   = flc;
    v[VB_LTC]   = ltc;
    v[VB_JUMBO] = jumbo;
    v[VB_VLAN]  = vlan;
    v[VB_EN]    = en;
    return v;
  endfunction

  function automatic logic [79:0] default_vec(input logic [47:0] mac, input logic [14:0] max_len,
                                              input logic is_rx);
    return pack_vec(mac, max_len, 1'b1, 1'b1, 1'b1, 1'b0, is_rx, is_rx);
  endfunction

  function automatic port_cfg_t default_cfg(input logic [47:0] mac, input logic [14:0] max_len);
    port_cfg_t c;
    c.mac        = mac;
    c.tx_len     = max_len;
    c.tx_en      = 1'b1;
    c.tx_vlan    = 1'b1;
    c.tx_jumbo   = 1'b1;
    c.tx_dic     = 1'b0;
    c.rx_len     = max_len;
    c.rx_en      = 1'b1;
    c.rx_vlan    = 1'b1;
    c.rx_jumbo   = 1'b1;
    c.rx_flc_dis = 1'b1;
    c.rx_ltc_dis = 1'b1;
    return c;
  endfunction

  function automatic logic [79:0] tx_vec(input port_cfg_t c, input logic force_dis);
    return pack_vec(c.mac, c.tx_len, c.tx_en & ~force_dis, c.tx_vlan, c.tx_jumbo, c.tx_dic,
                    1'b0, 1'b0);
  endfunction

  function automatic logic [79:0] rx_vec(input port_cfg_t c, input logic force_dis);
    return pack_vec(c.mac, c.rx_len, c.rx_en & ~force_dis, c.rx_vlan, c.rx_jumbo, 1'b0,
                    c.rx_flc_dis, c.rx_ltc_dis);
  endfunction

  function automatic logic [31:0] cfg_read(input port_cfg_t c, input logic [1:0] sel);
    logic [31:0] d;
    d = '0;
    case (sel)
      REG_MAC_LO: d = c.mac[31:0];
      REG_MAC_HI: d[15:0] = c.mac[47:32];
      REG_TX: begin
        d[14:0]      = c.tx_len;
        d[RB_EN]     = c.tx_en;
        d[RB_VLAN]   = c.tx_vlan;
        d[RB_JUMBO]  = c.tx_jumbo;
        d[RB_TX_DIC] = c.tx_dic;
      end
      REG_RX: begin
        d[14:0]      = c.rx_len;
        d[RB_EN]     = c.rx_en;
        d[RB_VLAN]   = c.rx_vlan;
        d[RB_JUMBO]  = c.rx_jumbo;
        d[RB_RX_FLC] = c.rx_flc_dis;
        d[RB_RX_LTC] = c.rx_ltc_dis;
      end
    endcase
    return d;
  endfunction

  function automatic port_cfg_t cfg_write(input port_cfg_t c, input logic [1:0] sel,
                                          input logic [31:0] d);
    port_cfg_t n;
    n = c;
    case (sel)
      REG_MAC_LO: n.mac[31:0] = d;
      REG_MAC_HI: n.mac[47:32] = d[15:0];
      REG_TX: begin
        n.tx_len   = d[14:0];
        n.tx_en    = d[RB_EN];
        n.tx_vlan  = d[RB_VLAN];
        n.tx_jumbo = d[RB_JUMBO];
        n.tx_dic   = d[RB_TX_DIC];
      end
      REG_RX: begin
        n.rx_len     = d[14:0];
        n.rx_en      = d[RB_EN];
        n.rx_vlan    = d[RB_VLAN];
        n.rx_jumbo   = d[RB_JUMBO];
        n.rx_flc_dis = d[RB_RX_FLC];
        n.rx_ltc_dis = d[RB_RX_LTC];
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/eth_mac_conf_if.sv
// Host register/commit bus of the MAC configuration block.
interface eth_mac_conf_if #(
  parameter int NPORTS    = 2,
  parameter int QUIESCE_W = 8
);
  localparam int AW = $clog2(NPORTS) + 2;

  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic [31:0]          cfg_wdata;
  logic [31:0]          cfg_rdata;
  logic                 cfg_commit;
  logic [NPORTS-1:0]    cfg_commit_mask;
  logic [QUIESCE_W-1:0] quiesce_len;
  logic                 busy;
  logic                 commit_err;
  logic [15:0]          commit_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_commit, cfg_commit_mask, quiesce_len,
    input  cfg_rdata, busy, commit_err, commit_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_commit, cfg_commit_mask, quiesce_len,
    output cfg_rdata, busy, commit_err, commit_cnt
  );
endinterface

// File: rtl/eth_mac_conf_port.sv
// One MAC port: shadow (host-visible) and active (MAC-driving) configuration,
// packed into the TX/RX configuration vectors.
module eth_mac_conf_port
  import eth_mac_conf_pkg::*;
#(
  parameter logic [47:0] MAC_RST     = 48'h001122334455,
  parameter logic [14:0] DEF_MAX_LEN = 15'd1518
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [1:0]  i_reg_sel,
  input  logic [31:0] i_wdata,
  input  logic        i_apply,
  input  logic        i_force_dis,
  output logic [31:0] o_rdata,
  output logic [79:0] o_tx_vec,
  output logic [79:0] o_rx_vec
);

  localparam port_cfg_t CFG_RST = default_cfg(MAC_RST, DEF_MAX_LEN);

  port_cfg_t r_shadow;
  port_cfg_t r_active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= CFG_RST;
      r_active <= CFG_RST;
    end else begin
      // NOTE: non-blocking assignment means a write coinciding with apply is
      // not seen by r_active; the pre-write shadow is what gets applied.
      if (i_apply) r_active <= r_shadow;
      if (i_we)    r_shadow <= cfg_write(r_shadow, i_reg_sel, i_wdata);
    end
  end

  assign o_rdata  = cfg_read(r_shadow, i_reg_sel);
  assign o_tx_vec = tx_vec(r_active, i_force_dis);
  assign o_rx_vec = rx_vec(r_active, i_force_dis);

endmodule

// File: rtl/eth_mac_conf_regs.sv
// Runtime MAC configuration: per-port shadow registers plus a commit FSM that
// quiesces the selected ports before loading shadow into the active vectors.
module eth_mac_conf_regs
  import eth_mac_conf_pkg::*;
#(
  parameter int                   NPORTS      = 2,
  parameter logic [47:0]          BASE_MAC    = 48'h001122334455,
  parameter logic [14:0]          DEF_MAX_LEN = 15'd1518,
  parameter int                   QUIESCE_W   = 8,
  parameter logic [QUIESCE_W-1:0] DEF_QUIESCE = 8'd16
) (
  input  logic                  clk156,
  input  logic                  sys_rst,
  eth_mac_conf_if.slave         cfg,
  output logic [80*NPORTS-1:0]  mac_tx_configuration_vector,
  output logic [80*NPORTS-1:0]  mac_rx_configuration_vector
);

  localparam int AW = $clog2(NPORTS) + 2;
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  state_t               r_state;
  logic [NPORTS-1:0]    r_mask;
  logic [NPORTS-1:0]    r_force;
  logic [QUIESCE_W-1:0] r_qcnt;
  logic                 r_busy;
  logic                 r_err;
  logic                 r_apply;
  logic [15:0]          r_cnt;
  logic [31:0]          r_rdata;

  logic [AW-1:0] w_addr_port;
  logic [PW-1:0] w_port;
  logic          w_in_range;
  logic          w_accept;
  logic [31:0]   w_port_rdata [NPORTS];

  assign w_addr_port = cfg.cfg_addr >> 2;
  assign w_port      = w_addr_port[PW-1:0];
  assign w_in_range  = w_addr_port < AW'(NPORTS);
  assign w_accept    = cfg.cfg_commit && (r_state == ST_IDLE) && (|cfg.cfg_commit_mask);

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_force <= '0;
      r_qcnt  <= DEF_QUIESCE;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_apply <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_err <= cfg.cfg_commit && !w_accept;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_QUIESCE;
            r_mask  <= cfg.cfg_commit_mask;
            r_force <= cfg.cfg_commit_mask;
            r_qcnt  <= cfg.quiesce_len;
            r_busy  <= 1'b1;
            r_cnt   <= r_cnt + 16'd1;
          end
        end
        ST_QUIESCE: begin
          // Length 0 still yields one quiesce cycle.
          if (r_qcnt == '0) begin
            r_state <= ST_APPLY;
            r_force <= '0;
            r_apply <= 1'b1;
          end else begin
            r_qcnt <= r_qcnt - 1'b1;
          end
        end
        ST_APPLY: begin
          r_state <= ST_IDLE;
          r_apply <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) r_rdata <= '0;
    else         r_rdata <= w_in_range ? w_port_rdata[w_port] : '0;
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    eth_mac_conf_port #(
      .MAC_RST     (BASE_MAC + 48'(p)),
      .DEF_MAX_LEN (DEF_MAX_LEN)
    ) u_port (
      .i_clk       (clk156),
      .i_rst       (sys_rst),
      .i_we        (cfg.cfg_we && w_in_range && (w_port == PW'(p))),
      .i_reg_sel   (cfg.cfg_addr[1:0]),
      .i_wdata     (cfg.cfg_wdata),
      .i_apply     (r_apply && r_mask[p]),
      .i_force_dis (r_force[p]),
      .o_rdata     (w_port_rdata[p]),
      .o_tx_vec    (mac_tx_configuration_vector[80*p +: 80]),
      .o_rx_vec    (mac_rx_configuration_vector[80*p +: 80])
    );
  end

  assign cfg.cfg_rdata  = r_rdata;
  assign cfg.busy       = r_busy;
  assign cfg.commit_err = r_err;
  assign cfg.commit_cnt = r_cnt;

endmodule

// File: tb/tb_eth_mac_conf_regs.sv
// Scoreboard bench for eth_mac_conf_regs (NPORTS=2): register readback,
// commit sequencing with quiesce, error pulses and reset mid-commit.
module tb_eth_mac_conf_regs;

  localparam int NP = 2;

  logic clk156 = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk156 = ~clk156;

  eth_mac_conf_if #(.NPORTS(NP), .QUIESCE_W(8)) cfg_bus ();
  logic [80*NP-1:0] tx_v;
  logic [80*NP-1:0] rx_v;

  eth_mac_conf_regs #(.NPORTS(NP)) dut (
    .clk156                      (clk156),
    .sys_rst                     (sys_rst),
    .cfg                         (cfg_bus),
    .mac_tx_configuration_vector (tx_v),
    .mac_rx_configuration_vector (rx_v)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_cnt = 0;

  typedef struct { string tag; logic [79:0] exp; } sb_t;
  sb_t sb_q[$];

  logic [31:0] m_sh  [NP][4];
  logic [31:0] m_act [NP][4];

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  function automatic logic [31:0] wmask(input int r);
    case (r)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_FFFF;
      2:       return 32'h000F_7FFF;
      default: return 32'h001F_7FFF;
    endcase
  endfunction

  function automatic logic [79:0] exp_vec(input int p, input bit is_rx, input bit forced);
    logic [31:0] w;
    logic [15:0] lo;
    w = is_rx ? m_act[p][3] : m_act[p][2];
    if (is_rx) lo = {6'b0, w[19], w[20], 3'b0, w[18], 1'b0, w[17], w[16] & ~forced, 1'b0};
    else       lo = {5'b0, w[19], 5'b0, w[18], 1'b0, w[17], w[16] & ~forced, 1'b0};
    return {m_act[p][1][15:0], m_act[p][0], 1'b0, w[14:0], lo};
  endfunction

  task automatic model_reset();
    logic [47:0] mac;
    for (int p = 0; p < NP; p++) begin
      mac = 48'h001122334455 + 48'(p);
      m_sh[p][0] = mac[31:0];
      m_sh[p][1] = {16'h0, mac[47:32]};
      m_sh[p][2] = 32'h0007_05EE;
      m_sh[p][3] = 32'h001F_05EE;
      m_act[p] = m_sh[p];
    end
    m_cnt = 0;
  endtask

  task automatic sb_pop(input logic [79:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 80'd1, 80'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic wr(input int p, input int r, input logic [31:0] d);
    cfg_bus.cfg_we    = 1'b1;
    cfg_bus.cfg_addr  = {p[0], r[1:0]};
    cfg_bus.cfg_wdata = d;
    tick();
    cfg_bus.cfg_we = 1'b0;
    m_sh[p][r] = d & wmask(r);
  endtask

  task automatic rd(input int p, input int r);
    cfg_bus.cfg_addr = {p[0], r[1:0]};
    sb_q.push_back('{$sformatf("rdata_p%0d_r%0d", p, r), {48'h0, m_sh[p][r]}});
    tick();
    sb_pop({48'h0, cfg_bus.cfg_rdata});
  endtask

  task automatic chk_all_vecs(input string tag);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s_p%0d_tx", tag, p), tx_v[80*p +: 80], exp_vec(p, 0, 0));
      check($sformatf("%s_p%0d_rx", tag, p), rx_v[80*p +: 80], exp_vec(p, 1, 0));
    end
  endtask

  // Runs one accepted commit; optionally fires a commit while busy and a
  // shadow write in the APPLY cycle (port1 reg2).
  task automatic run_commit(input logic [NP-1:0] mask, input logic [7:0] len,
                            input bit probe_busy, input bit apply_write);
    logic [31:0] snap [NP][4];
    int low, errs;
    bit all_low, wrote;
    snap = m_sh;
    for (int p = 0; p < NP; p++) begin
      sb_q.push_back('{$sformatf("post_commit_p%0d_tx", p),
                       mask[p] ? {snap[p][1][15:0], snap[p][0], 1'b0, snap[p][2][14:0],
                                  5'b0, snap[p][2][19], 5'b0, snap[p][2][18], 1'b0,
                                  snap[p][2][17], snap[p][2][16], 1'b0}
                               : exp_vec(p, 0, 0)});
      sb_q.push_back('{$sformatf("post_commit_p%0d_rx", p),
                       mask[p] ? {snap[p][1][15:0], snap[p][0], 1'b0, snap[p][3][14:0],
                                  6'b0, snap[p][3][19], snap[p][3][20], 3'b0, snap[p][3][18],
                                  1'b0, snap[p][3][17], snap[p][3][16], 1'b0}
                               : exp_vec(p, 1, 0)});
    end
    cfg_bus.cfg_commit      = 1'b1;
    cfg_bus.cfg_commit_mask = mask;
    cfg_bus.quiesce_len     = len;
    tick();
    cfg_bus.cfg_commit = 1'b0;
    m_cnt++;
    check("busy_after_accept", 80'(cfg_bus.busy), 80'd1);
    check("cnt_after_accept", 80'(cfg_bus.commit_cnt), 80'(m_cnt[15:0]));
    low = 0;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      if (!cfg_bus.busy) break;
      all_low = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (mask[p] && (tx_v[80*p+1] || rx_v[80*p+1])) all_low = 1'b0;
        if (!mask[p]) check($sformatf("untouched_p%0d_tx", p), tx_v[80*p +: 80], exp_vec(p, 0, 0));
      end
      if (all_low) low++;
      if (cfg_bus.commit_err) errs++;
      cfg_bus.cfg_commit      = probe_busy && (i == 1);
      cfg_bus.cfg_commit_mask = 2'b01;
      wrote = apply_write && (i == int'(len) + 1);
      cfg_bus.cfg_we    = wrote;
      cfg_bus.cfg_addr  = 3'b110;
      cfg_bus.cfg_wdata = 32'h0000_0100;
      tick();
      cfg_bus.cfg_commit = 1'b0;
      cfg_bus.cfg_we     = 1'b0;
      if (wrote) m_sh[1][2] = 32'h0000_0100;
    end
    check("commit_done", 80'(cfg_bus.busy), 80'd0);
    check("quiesce_cycles", 80'(low), 80'(int'(len) + 1));
    check("busy_commit_err_pulses", 80'(errs), probe_busy ? 80'd1 : 80'd0);
    check("cnt_after_commit", 80'(cfg_bus.commit_cnt), 80'(m_cnt[15:0]));
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) m_act[p] = snap[p];
      sb_pop(tx_v[80*p +: 80]);
      sb_pop(rx_v[80*p +: 80]);
    end
  endtask

  initial begin
    cfg_bus.cfg_we          = 1'b0;
    cfg_bus.cfg_addr        = '0;
    cfg_bus.cfg_wdata       = '0;
    cfg_bus.cfg_commit      = 1'b0;
    cfg_bus.cfg_commit_mask = '0;
    cfg_bus.quiesce_len     = '0;
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    model_reset();

    // Reset state, against literal values as well as the model.
    check("rst_p0_tx", tx_v[79:0], {48'h001122334455, 1'b0, 15'd1518, 16'h0016});
    check("rst_p1_mac", 80'(tx_v[159:112]), 80'h0000_0000_0011_2233_4456);
    check("rst_p0_rx_lo", 80'(rx_v[15:0]), 80'h0316);
    check("rst_busy", 80'(cfg_bus.busy), 80'd0);
    check("rst_err", 80'(cfg_bus.commit_err), 80'd0);
    check("rst_cnt", 80'(cfg_bus.commit_cnt), 80'd0);
    check("rst_rdata", 80'(cfg_bus.cfg_rdata), 80'd0);
    chk_all_vecs("rst");

    // Shadow writes and readback; active vectors stay put.
    wr(1, 2, 32'h0001_2328);
    rd(1, 2);
    chk_all_vecs("no_commit_yet");
    wr(1, 0, 32'hDEAD_BEEF);
    wr(1, 1, 32'hFFFF_ABCD);
    wr(1, 3, 32'hFFFF_FFFF);
    rd(1, 1);
    rd(1, 3);
    rd(0, 0);
    rd(1, 0);
    chk_all_vecs("shadow_only");

    // Port1 commit, len 5, with a commit-while-busy and a write during APPLY.
    run_commit(2'b10, 8'd5, 1'b1, 1'b1);
    check("tx_len_9000", 80'(tx_v[80+16 +: 15]), 80'd9000);
    rd(1, 2);

    // Mask-zero commit is rejected without side effects.
    cfg_bus.cfg_commit      = 1'b1;
    cfg_bus.cfg_commit_mask = 2'b00;
    tick();
    cfg_bus.cfg_commit = 1'b0;
    check("mask0_err", 80'(cfg_bus.commit_err), 80'd1);
    check("mask0_busy", 80'(cfg_bus.busy), 80'd0);
    check("mask0_cnt", 80'(cfg_bus.commit_cnt), 80'(m_cnt[15:0]));
    tick();
    check("mask0_err_single", 80'(cfg_bus.commit_err), 80'd0);
    chk_all_vecs("mask0");

    // Port0 commit with the minimum quiesce length.
    wr(0, 3, 32'h0000_0040);
    run_commit(2'b01, 8'd0, 1'b0, 1'b0);

    // Reset asserted in the middle of QUIESCE.
    cfg_bus.cfg_commit      = 1'b1;
    cfg_bus.cfg_commit_mask = 2'b11;
    cfg_bus.quiesce_len     = 8'd20;
    tick();
    cfg_bus.cfg_commit = 1'b0;
    m_cnt++;
    tick();
    tick();
    check("mid_busy", 80'(cfg_bus.busy), 80'd1);
    check("mid_cnt", 80'(cfg_bus.commit_cnt), 80'(m_cnt[15:0]));
    check("mid_force_p0_tx", tx_v[79:0], exp_vec(0, 0, 1));
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    model_reset();
    check("abort_busy", 80'(cfg_bus.busy), 80'd0);
    check("abort_cnt", 80'(cfg_bus.commit_cnt), 80'd0);
    chk_all_vecs("abort");
    rd(1, 2);
    tick();
    check("abort_stays_idle", 80'(cfg_bus.busy), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_mac_conf_regs.md
Name: eth_mac_conf_regs

Overview:
Runtime-programmable MAC configuration block for NPORTS 10G MAC instances, replacing fixed tie-off configuration vectors. A host register port writes per-port shadow registers. A commit request quiesces the selected ports' TX/RX enables for a programmable number of cycles, then loads the shadow values into the active vectors that drive the MAC cores.

Parameters:
NPORTS, 2, number of MAC ports (1..8)
BASE_MAC, 48'h001122334455, reset MAC of port 0; port p resets to BASE_MAC + p
DEF_MAX_LEN, 15'd1518, reset TX/RX max frame length
QUIESCE_W, 8, width of quiesce counter
DEF_QUIESCE, 8'd16, reset quiesce length in cycles

Ports:
clk156  in  1  core clock
sys_rst  in  1  synchronous active-high reset
cfg_we  in  1  register write strobe
cfg_addr  in  $clog2(NPORTS)+2  {port, reg[1:0]}
cfg_wdata  in  32  write data
cfg_rdata  out  32  shadow readback, 1-cycle latency
cfg_commit  in  1  commit request pulse
cfg_commit_mask  in  NPORTS  ports to update
quiesce_len  in  QUIESCE_W  quiesce cycles, sampled at commit accept
busy  out  1  commit in progress
commit_err  out  1  1-cycle pulse: commit rejected
commit_cnt  out  16  accepted commits, wraps
mac_tx_configuration_vector  out  80*NPORTS  port p at [80p+79:80p]
mac_rx_configuration_vector  out  80*NPORTS  same layout

Behaviour:
- Register map per port: reg0 = MAC[31:0]; reg1[15:0] = MAC[47:32]; reg2 = TX: [14:0] max len, [16] enable, [17] VLAN, [18] jumbo, [19] DIC; reg3 = RX: [14:0] max len, [16] enable, [17] VLAN, [18] jumbo, [19] frame-length-check disable, [20] length/type-check disable. Unlisted bits write-ignored, read 0.
- Vector layout: [79:32] MAC, [30:16] max len, [10] DIC (TX only), [9] frame-length-check disable (RX only), [8] length/type-check disable (RX only), [4] jumbo, [2] VLAN, [1] enable. All other bits constant 0.
- Reset: shadow and active registers load defaults: MAC = BASE_MAC+p, max len DEF_MAX_LEN, enable=1, VLAN=1, jumbo=1, DIC=0, RX both check-disables=1. busy=0, commit_err=0, commit_cnt=0, cfg_rdata=0. Vectors carry defaults in the first cycle after reset.
- Writes update shadow only, next cycle. They are accepted in any state, including busy.
- Out-of-range port index: write dropped, read returns 0.
- cfg_rdata: registered shadow value of cfg_addr from the previous cycle.
- FSM IDLE -> QUIESCE -> APPLY -> IDLE.
  - IDLE: cfg_commit with nonzero mask: latch mask and quiesce_len, commit_cnt++, busy=1 next cycle, go to QUIESCE.
  - QUIESCE: the enable bits (bit 1) of masked ports are forced 0 on both vectors; all other bits stay at active values. The counter counts down the latched length; len=0 means one cycle. Go to APPLY at terminal count.
  - APPLY: one cycle. Active <= shadow for masked ports, forced-enable cleared. Next cycle: IDLE, busy=0. New vectors are visible on the cycle after APPLY.
- cfg_commit while busy: ignored, commit_err pulses, commit_cnt unchanged.
- cfg_commit with mask 0: ignored, commit_err pulses.
- A write in the same cycle as APPLY to the same register: the pre-write shadow value is applied. The write lands in shadow only.
- Unmasked ports are never disturbed.
- sys_rst mid-commit: immediate return to IDLE with all defaults restored. The aborted commit is not counted beyond the increment already made (counter resets to 0).
- commit_cnt wraps 16'hFFFF -> 0.

Decomposition:
- Package eth_mac_conf_pkg: register offset constants, vector bit-position constants, and a default-vector function of (mac, maxlen, is_rx).
- One sub-module eth_mac_conf_port: per-port shadow/active registers and vector packing. The top holds the FSM, counter, readback mux and error logic.

Test Plan:
- Reset, NPORTS=2 -> port0 TX vector = {48'h001122334455,1'b0,15'd1518,16'h0016}; port1 MAC 48'h001122334456; RX low 16 bits 16'h0316.
- Write port1 reg2 = 32'h0001_2328, then read -> cfg_rdata 32'h0001_2328 one cycle later; vectors unchanged until commit.
- Commit mask 2'b10, quiesce_len 5 -> port1 bit1 low for 6 cycles, then TX [30:16]=9000; port0 untouched throughout; commit_cnt=1.
- Commit while busy -> commit_err single pulse; active commit completes unchanged; commit_cnt=1.
- Commit with mask 0 -> commit_err pulse, no state change.
- sys_rst asserted during QUIESCE -> next cycle busy=0, defaults on all vectors, commit_cnt=0.
